// File: rtl/btn_rst_ctrl.sv
// Button conditioner and SoC reset sequencer. Each button gets a 2-flop synchroniser,
// a stability-counter debouncer and one-cycle press/release strobes.
module btn_rst_ctrl #(
    parameter int                   NUM_BTN         = 7,
    parameter logic [NUM_BTN-1:0]   BTN_IDLE        = 7'b0000001,
    parameter int                   DEBOUNCE_CYCLES = 250000,
    parameter int                   RST_HOLD_CYCLES = 1024,
    parameter int                   RST_BTN         = 0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_BTN-1:0] btn_i,
    input  logic               sw_rst_i,
    output logic [NUM_BTN-1:0] btn_db_o,
    output logic [NUM_BTN-1:0] btn_press_o,
    output logic [NUM_BTN-1:0] btn_release_o,
    output logic               soc_rst_no,
    output logic [1:0]         rst_cause_o
);

    localparam int                DB_W      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam int                HOLD_W    = $clog2(RST_HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);

    logic [NUM_BTN-1:0] db_all;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            logic            sync1_q;
            logic            sync2_q;
            logic            db_q;
            logic            db_d;
            logic            press_q;
            logic            press_d;
            logic            rel_q;
            logic            rel_d;
            logic [DB_W-1:0] cnt_q;
            logic [DB_W-1:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                db_d  = db_q;
                if (sync2_q == db_q) begin
                    cnt_d = '0;
                end else if (cnt_q == DB_LAST) begin
                    db_d  = sync2_q;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Strobes are registered alongside db_q so they mark its first new cycle.
                press_d = (db_d != db_q) && (db_d != BTN_IDLE[gi]);
                rel_d   = (db_d != db_q) && (db_d == BTN_IDLE[gi]);
            end

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    sync1_q <= BTN_IDLE[gi];
                    sync2_q <= BTN_IDLE[gi];
                    db_q    <= BTN_IDLE[gi];
                    cnt_q   <= '0;
                    press_q <= 1'b0;
                    rel_q   <= 1'b0;
                end else begin
                    sync1_q <= btn_i[gi];
                    sync2_q <= sync1_q;
                    db_q    <= db_d;
                    cnt_q   <= cnt_d;
                    press_q <= press_d;
                    rel_q   <= rel_d;
                end
            end

            assign db_all[gi]        = db_q;
            assign btn_press_o[gi]   = press_q;
            assign btn_release_o[gi] = rel_q;
        end
    endgenerate

    assign btn_db_o = db_all;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_HOLD  = 2'd1,
        S_RUN   = 2'd2
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic [1:0]        cause_q;
    logic [1:0]        cause_d;
    logic              soc_q;
    logic              soc_d;
    logic              rst_btn;

    assign rst_btn = (db_all[RST_BTN] != BTN_IDLE[RST_BTN]);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cause_d = cause_q;
        unique case (state_q)
            S_RESET: begin
                hold_d = '0;
                if (!rst_btn) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (rst_btn) begin
                    state_d = S_RESET;
                    hold_d  = '0;
                    cause_d = 2'd1;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = S_RUN;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_RUN: begin
                // The button takes priority over a coincident software request.
                if (rst_btn) begin
                    state_d = S_RESET;
                    cause_d = 2'd1;
                end else if (sw_rst_i) begin
                    state_d = S_RESET;
                    cause_d = 2'd2;
                end
            end
            default: begin
                state_d = S_RESET;
                hold_d  = '0;
            end
        endcase
        soc_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_RESET;
            hold_q  <= '0;
            cause_q <= 2'd0;
            soc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cause_q <= cause_d;
            soc_q   <= soc_d;
        end
    end

    assign soc_rst_no  = soc_q;
    assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_btn_rst_ctrl.sv
// Scoreboard bench for btn_rst_ctrl: a cycle-level reference model pushes the expected
// outputs after each edge, and a negedge monitor pops and compares them.
module tb_btn_rst_ctrl;

    localparam int         NB   = 7;
    localparam logic [6:0] IDLE = 7'b0000001;
    localparam int         DB   = 4;
    localparam int         HOLD = 8;
    localparam int         RB   = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] btn = IDLE;
    logic       sw = 1'b0;
    logic [6:0] btn_db;
    logic [6:0] btn_press;
    logic [6:0] btn_release;
    logic       soc_rst_n;
    logic [1:0] rst_cause;

    always #5 clk = ~clk;

    btn_rst_ctrl #(
        .NUM_BTN        (NB),
        .BTN_IDLE       (IDLE),
        .DEBOUNCE_CYCLES(DB),
        .RST_HOLD_CYCLES(HOLD),
        .RST_BTN        (RB)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .btn_i        (btn),
        .sw_rst_i     (sw),
        .btn_db_o     (btn_db),
        .btn_press_o  (btn_press),
        .btn_release_o(btn_release),
        .soc_rst_no   (soc_rst_n),
        .rst_cause_o  (rst_cause)
    );

    typedef struct packed {
        logic [6:0] db;
        logic [6:0] press;
        logic [6:0] rel;
        logic       soc;
        logic [1:0] cause;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   done = 0;

    // Reference model state: the level each button is believed to hold, how long the
    // synchronised input has disagreed with it, and the reset sequencer's progress.
    logic [6:0] m_db;
    int         m_run[NB];
    logic [6:0] m_pipe[$];
    bit         m_running;
    int         m_wait;
    logic [1:0] m_cause;

    task automatic model_edge();
        exp_t       e;
        logic [6:0] synced;
        logic [6:0] new_db;
        logic [6:0] chg;
        logic       rst_btn;
        if (!rst_n) begin
            m_db      = IDLE;
            for (int i = 0; i < NB; i++) m_run[i] = 0;
            m_pipe    = '{IDLE, IDLE};
            m_running = 0;
            m_wait    = 0;
            m_cause   = 2'd0;
            e.press   = '0;
            e.rel     = '0;
        end else begin
            synced  = m_pipe[0];
            rst_btn = (m_db[RB] != IDLE[RB]);
            new_db  = m_db;
            for (int i = 0; i < NB; i++) begin
                if (synced[i] != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        new_db[i] = synced[i];
                        m_run[i]  = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            chg     = new_db ^ m_db;
            e.press = chg & (new_db ^ IDLE);
            e.rel   = chg & ~(new_db ^ IDLE);
            if (m_running) begin
                if (rst_btn) begin
                    m_cause = 2'd1; m_running = 0; m_wait = 0;
                end else if (sw) begin
                    m_cause = 2'd2; m_running = 0; m_wait = 0;
                end
            end else if (rst_btn) begin
                if (m_wait > 0) m_cause = 2'd1;
                m_wait = 0;
            end else begin
                m_wait++;
                if (m_wait == HOLD + 1) m_running = 1;
            end
            m_db = new_db;
            void'(m_pipe.pop_front());
            m_pipe.push_back(btn);
        end
        e.db    = m_db;
        e.soc   = m_running;
        e.cause = m_cause;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic [6:0] b, input logic s);
        rst_n = r;
        btn   = b;
        sw    = s;
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, IDLE, 1'b0);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        logic prev_soc;
        prev_soc = 1'b0;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                if (!done) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_underflow cyc=%0d got=empty exp=entry", cyc);
                end
            end else begin
                e = exp_q.pop_front();
                chk("btn_db",      32'(btn_db),      32'(e.db));
                chk("btn_press",   32'(btn_press),   32'(e.press));
                chk("btn_release", 32'(btn_release), 32'(e.rel));
                chk("soc_rst_n",   32'(soc_rst_n),   32'(e.soc));
                chk("rst_cause",   32'(rst_cause),   32'(e.cause));
                if ((e.press | e.rel) != 0 || e.soc != prev_soc)
                    $display("cyc=%0d db=%b press=%b rel=%b soc_rst_n=%b cause=%0d",
                             cyc, btn_db, btn_press, btn_release, soc_rst_n, rst_cause);
                prev_soc = e.soc;
            end
        end
    end

    initial begin : stimulus
        logic [6:0] rb;
        logic       rs;
        logic       rr;
        // Power-on
        for (int i = 0; i < 3; i++) step(1'b0, IDLE, 1'b0);
        idle(15);
        // Clean press/release of button 3
        for (int i = 0; i < 10; i++) step(1'b1, IDLE | 7'b0001000, 1'b0);
        idle(15);
        // Bounce that never reaches the stability threshold
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 3; i++) step(1'b1, IDLE | 7'b0001000, 1'b0);
            step(1'b1, IDLE, 1'b0);
        end
        idle(10);
        // Reset button (active low) held, then released
        for (int i = 0; i < 20; i++) step(1'b1, 7'b0000000, 1'b0);
        idle(20);
        // Software reset, then a second request during HOLD
        step(1'b1, IDLE, 1'b1);
        idle(3);
        step(1'b1, IDLE, 1'b1);
        idle(15);
        // Debounced reset-button press while in HOLD
        step(1'b1, IDLE, 1'b1);
        idle(2);
        for (int i = 0; i < 8; i++) step(1'b1, 7'b0000000, 1'b0);
        idle(25);
        // Software request on the same cycle the debounced button is first seen
        for (int i = 0; i < 12; i++) step(1'b1, 7'b0000000, (i == 6));
        idle(25);
        // Board reset in the middle of HOLD and in the middle of a debounce
        step(1'b1, IDLE, 1'b1);
        idle(3);
        step(1'b0, IDLE, 1'b0);
        step(1'b0, IDLE, 1'b0);
        idle(15);
        for (int i = 0; i < 3; i++) step(1'b1, IDLE | 7'b0100000, 1'b0);
        step(1'b0, IDLE | 7'b0100000, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, IDLE | 7'b0100000, 1'b0);
        idle(15);
        // Randomised traffic
        rb = IDLE;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) rb[$urandom_range(0, NB - 1)] ^= 1'b1;
            rs = ($urandom_range(0, 39) == 0);
            rr = !($urandom_range(0, 499) == 0);
            step(rr, rb, rs);
        end
        idle(20);
        done = 1;
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
